// File: rtl/serial_word_detector.sv
// rtl/serial_word_detector.sv - serial word slicer with selectable match and stretched detection flag
// Assembles MSB-first words, strobes each completed word and counts matches (saturating).
module serial_word_detector #(
  parameter int WIDTH       = 3,
  parameter int HOLD_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in,
  input  logic             in_valid,
  input  logic             frame,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] pattern,
  output logic             out,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic [CNT_W-1:0] match_count
);

  localparam int IW = $clog2(WIDTH);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic [WIDTH-1:0] sr;
  logic [IW-1:0]    idx;
  logic [HW-1:0]    hold;
  logic [WIDTH-1:0] new_word;
  logic             complete;
  logic             hit;

  always_comb begin
    new_word = {sr[WIDTH-2:0], in};
    complete = in_valid && !frame && (idx == IW'(WIDTH - 1));
    hit      = 1'b0;
    if (complete) begin
      case (mode)
        2'b00:   hit = new_word[0];
        2'b01:   hit = !new_word[0];
        2'b10:   hit = (new_word == pattern);
        default: hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sr          <= '0;
      idx         <= '0;
      hold        <= '0;
      out         <= 1'b0;
      word        <= '0;
      word_valid  <= 1'b0;
      match_count <= '0;
    end else begin
      word_valid <= 1'b0;
      if (in_valid) begin
        sr <= new_word;
        // A frame bit always starts a fresh word, even at the completing position.
        if (frame) begin
          idx <= IW'(1);
        end else if (complete) begin
          idx        <= '0;
          word       <= new_word;
          word_valid <= 1'b1;
        end else begin
          idx <= idx + IW'(1);
        end
      end

      // Hold counter runs regardless of in_valid; a match reloads it so pulses merge.
      if (hit) begin
        hold <= HW'(HOLD_CYCLES);
        out  <= 1'b1;
        if (match_count != {CNT_W{1'b1}})
          match_count <= match_count + CNT_W'(1);
      end else if (hold > HW'(1)) begin
        hold <= hold - HW'(1);
        out  <= 1'b1;
      end else begin
        hold <= '0;
        out  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_detector.sv
// tb/tb_serial_word_detector.sv - scoreboard bench for serial_word_detector
// Expected outputs are pushed per driven cycle and popped after the clock edge.
module tb_serial_word_detector;

  localparam int WIDTH = 3;
  localparam int HOLD  = 3;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in = 1'b0;
  logic             in_valid = 1'b0;
  logic             frame = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] pattern = '0;
  logic             out;
  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic [CNT_W-1:0] match_count;

  serial_word_detector #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .in(in), .in_valid(in_valid), .frame(frame),
    .mode(mode), .pattern(pattern), .out(out), .word(word), .word_valid(word_valid),
    .match_count(match_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic             out;
    logic             wv;
    logic [WIDTH-1:0] word;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference state kept in terms of the spec: bits collected so far, cycles of flag remaining.
  logic [WIDTH-1:0] m_bits;
  int               m_nbits;
  logic [WIDTH-1:0] m_word;
  int               m_rem;
  int               m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic step(input logic rst_n_v, input logic b, input logic v, input logic f);
    exp_t e;
    logic hit;
    logic wv;
    reset_n  = rst_n_v;
    in       = b;
    in_valid = v;
    frame    = f;
    hit = 1'b0;
    wv  = 1'b0;
    if (!rst_n_v) begin
      m_bits = '0; m_nbits = 0; m_word = '0; m_rem = 0; m_cnt = 0;
    end else begin
      if (v) begin
        m_bits = {m_bits[WIDTH-2:0], b};
        if (f) m_nbits = 1;
        else begin
          m_nbits++;
          if (m_nbits == WIDTH) begin
            m_nbits = 0;
            m_word  = m_bits;
            wv      = 1'b1;
            case (mode)
              2'b00: hit = (m_bits[0] == 1'b1);
              2'b01: hit = (m_bits[0] == 1'b0);
              2'b10: hit = (m_bits == pattern);
              default: hit = 1'b0;
            endcase
          end
        end
      end
      if (hit) begin
        m_rem = HOLD;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end else if (m_rem > 0) begin
        m_rem--;
      end
    end
    e.out  = (m_rem > 0);
    e.wv   = wv;
    e.word = m_word;
    e.cnt  = CNT_W'(m_cnt);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("out", 32'(out), 32'(e.out));
      check("word_valid", 32'(word_valid), 32'(e.wv));
      check("word", 32'(word), 32'(e.word));
      check("match_count", 32'(match_count), 32'(e.cnt));
    end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) step(1'b1, w[i], 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m_bits = '0; m_nbits = 0; m_word = '0; m_rem = 0; m_cnt = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Odd match, single pulse
    mode = 2'b00;
    send_word(3'b101);
    idle(4);
    check("count_after_first", 32'(match_count), 32'd1);

    // Even word in odd mode, then even mode, then zero word
    send_word(3'b110);
    idle(4);
    mode = 2'b01;
    send_word(3'b110);
    idle(4);
    send_word(3'b000);
    idle(4);

    // Back-to-back matching words merge into one pulse
    mode = 2'b00;
    send_word(3'b011);
    send_word(3'b111);
    send_word(3'b001);
    idle(5);

    // Stall between bits 2 and 3 while an earlier hold is still running
    send_word(3'b111);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(5);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);

    // Frame discards a partial word; pattern match
    mode    = 2'b10;
    pattern = 3'b111;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);

    // Frame on the completing bit position: no completion, restarts word
    pattern = 3'b101;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);

    // Detection disabled
    mode = 2'b11;
    send_word(3'b101);
    idle(4);

    // Saturate counter, then reset during an active hold
    mode = 2'b00;
    for (int k = 0; k < 260; k++) send_word(3'b111);
    check("count_saturated", 32'(match_count), 32'd255);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("out_after_reset", 32'(out), 32'd0);
    check("count_after_reset", 32'(match_count), 32'd0);

    // After release the first bit is an MSB again
    mode = 2'b01;
    send_word(3'b100);
    idle(4);
    check("count_after_release", 32'(match_count), 32'd1);

    if (exp_q.size() != 0) check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
